// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the control pipeline: the decoder bundle, its bubble value and forwarding encodings.
package ctrl_pipe_pkg;

    typedef struct packed {
        logic       RegDst;
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       Jump;
        logic [1:0] ALUOp;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// Stall, flush, branch/jump resolution and ALU forwarding selects.
// Latency: purely combinational. Backpressure: it produces the stall; it never receives one.
module hazard_fwd_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             id_Jump,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_MemRead,
    input  logic             ex_Branch,
    input  logic             ex_zero,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_RegWrite,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             wb_RegWrite,
    input  logic [REG_W-1:0] wb_dst,
    output logic             stall,
    output logic             flush_if,
    output logic             branch_taken,
    output logic             jump_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             m_wr,
        input logic [REG_W-1:0] m_dst,
        input logic             w_wr,
        input logic [REG_W-1:0] w_dst
    );
        if (m_wr && (m_dst != '0) && (m_dst == src)) return FWD_MEM;
        if (w_wr && (w_dst != '0) && (w_dst == src)) return FWD_WB;
        return FWD_RF;
    endfunction

    logic load_use;

    assign load_use = ex_MemRead && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // A taken branch squashes the ID instruction, so any hazard or jump it carries is moot.
    assign branch_taken = ex_Branch & ex_zero;
    assign stall        = load_use & ~branch_taken;
    assign jump_taken   = id_Jump & ~branch_taken & ~stall;
    assign flush_if     = branch_taken | jump_taken;

    assign fwd_a = fwd_sel(ex_rs, mem_RegWrite, mem_dst, wb_RegWrite, wb_dst);
    assign fwd_b = fwd_sel(ex_rt, mem_RegWrite, mem_dst, wb_RegWrite, wb_dst);

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoder controls through ID/EX, EX/MEM and MEM/WB and hosts the hazard/forwarding unit.
// Latency: 1/2/3 edges ID->EX/MEM/WB. Backpressure: stall holds PC/IF/ID; ID/EX takes a bubble.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_RegDst,
    input  logic             id_ALUSrc,
    input  logic             id_MemtoReg,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_Branch,
    input  logic             id_Jump,
    input  logic [1:0]       id_ALUOp,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    output logic             ex_ALUSrc,
    output logic [1:0]       ex_ALUOp,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic             wb_RegWrite,
    output logic             wb_MemtoReg,
    output logic [REG_W-1:0] wb_dst,
    output logic             stall,
    output logic             flush_if,
    output logic             branch_taken,
    output logic             jump_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    ctrl_bundle_t     id_ctrl;
    ctrl_bundle_t     ex_ctrl;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_rd;
    logic             mem_RegWrite;
    logic             mem_MemtoReg;
    logic [REG_W-1:0] mem_dst;
    logic             ex_bubble;
    logic             unused_ex_jump;

    assign id_ctrl = '{RegDst:   id_RegDst,
                       ALUSrc:   id_ALUSrc,
                       MemtoReg: id_MemtoReg,
                       RegWrite: id_RegWrite,
                       MemRead:  id_MemRead,
                       MemWrite: id_MemWrite,
                       Branch:   id_Branch,
                       Jump:     id_Jump,
                       ALUOp:    id_ALUOp};

    assign ex_bubble      = stall | branch_taken;
    assign ex_ALUSrc      = ex_ctrl.ALUSrc;
    assign ex_ALUOp       = ex_ctrl.ALUOp;
    // The jump has already redirected the PC from ID; nothing downstream needs it.
    assign unused_ex_jump = ex_ctrl.Jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl      <= CTRL_BUBBLE;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_RegWrite <= 1'b0;
            mem_MemtoReg <= 1'b0;
            mem_dst      <= '0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
            wb_dst       <= '0;
        end else begin
            // A bubble clears the register fields too, so it looks exactly like a reset slot.
            if (ex_bubble) begin
                ex_ctrl <= CTRL_BUBBLE;
                ex_rs   <= '0;
                ex_rt   <= '0;
                ex_rd   <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rs   <= id_rs;
                ex_rt   <= id_rt;
                ex_rd   <= id_rd;
            end
            mem_MemRead  <= ex_ctrl.MemRead;
            mem_MemWrite <= ex_ctrl.MemWrite;
            mem_RegWrite <= ex_ctrl.RegWrite;
            mem_MemtoReg <= ex_ctrl.MemtoReg;
            mem_dst      <= ex_ctrl.RegDst ? ex_rd : ex_rt;
            wb_RegWrite  <= mem_RegWrite;
            wb_MemtoReg  <= mem_MemtoReg;
            wb_dst       <= mem_dst;
        end
    end

    hazard_fwd_unit #(
        .REG_W (REG_W)
    ) u_hazard_fwd (
        .id_Jump      (id_Jump),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_MemRead   (ex_ctrl.MemRead),
        .ex_Branch    (ex_ctrl.Branch),
        .ex_zero      (ex_zero),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_RegWrite (mem_RegWrite),
        .mem_dst      (mem_dst),
        .wb_RegWrite  (wb_RegWrite),
        .wb_dst       (wb_dst),
        .stall        (stall),
        .flush_if     (flush_if),
        .branch_taken (branch_taken),
        .jump_taken   (jump_taken),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Random and directed instruction streams against a queue-of-instructions model of the pipeline.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       RegDst;
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       Jump;
        logic [1:0] ALUOp;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
    logic       id_MemRead, id_MemWrite, id_Branch, id_Jump;
    logic [1:0] id_ALUOp;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic       ex_ALUSrc;
    logic [1:0] ex_ALUOp;
    logic       mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
    logic [4:0] wb_dst;
    logic       stall, flush_if, branch_taken, jump_taken;
    logic [1:0] fwd_a, fwd_b;

    int n_cmp = 0;
    int n_bad = 0;

    // pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB; all-zero entry = empty slot.
    ins_t pipe [3];
    bit   mdl_st, mdl_br, mdl_fl;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
        .stall(stall), .flush_if(flush_if), .branch_taken(branch_taken),
        .jump_taken(jump_taken), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] dst_of(input ins_t i);
        return i.RegDst ? i.rd : i.rt;
    endfunction

    // Newest writer of src among MEM then WB; register 0 is never forwarded.
    function automatic logic [1:0] fwd_exp(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (pipe[1].RegWrite && dst_of(pipe[1]) == src) return 2'b10;
        if (pipe[2].RegWrite && dst_of(pipe[2]) == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic apply(input ins_t i, input bit z);
        id_RegDst   = i.RegDst;   id_ALUSrc   = i.ALUSrc;
        id_MemtoReg = i.MemtoReg; id_RegWrite = i.RegWrite;
        id_MemRead  = i.MemRead;  id_MemWrite = i.MemWrite;
        id_Branch   = i.Branch;   id_Jump     = i.Jump;
        id_ALUOp    = i.ALUOp;
        id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        ex_zero = z;
    endtask

    task automatic check_all(input ins_t cur, input bit z);
        bit lu, jt;
        mdl_br = pipe[0].Branch && z;
        lu     = pipe[0].MemRead && pipe[0].rt != 5'd0 &&
                 (pipe[0].rt == cur.rs || pipe[0].rt == cur.rt);
        mdl_st = lu && !mdl_br;
        jt     = cur.Jump && !mdl_br && !mdl_st;
        mdl_fl = mdl_br || jt;
        check_eq("stall",        32'(stall),        32'(mdl_st));
        check_eq("branch_taken", 32'(branch_taken), 32'(mdl_br));
        check_eq("jump_taken",   32'(jump_taken),   32'(jt));
        check_eq("flush_if",     32'(flush_if),     32'(mdl_fl));
        check_eq("fwd_a",        32'(fwd_a),        32'(fwd_exp(pipe[0].rs)));
        check_eq("fwd_b",        32'(fwd_b),        32'(fwd_exp(pipe[0].rt)));
        check_eq("ex_ALUSrc",    32'(ex_ALUSrc),    32'(pipe[0].ALUSrc));
        check_eq("ex_ALUOp",     32'(ex_ALUOp),     32'(pipe[0].ALUOp));
        check_eq("mem_MemRead",  32'(mem_MemRead),  32'(pipe[1].MemRead));
        check_eq("mem_MemWrite", 32'(mem_MemWrite), 32'(pipe[1].MemWrite));
        check_eq("wb_RegWrite",  32'(wb_RegWrite),  32'(pipe[2].RegWrite));
        check_eq("wb_MemtoReg",  32'(wb_MemtoReg),  32'(pipe[2].MemtoReg));
        check_eq("wb_dst",       32'(wb_dst),       32'(dst_of(pipe[2])));
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ex_ALUSrc",  32'(ex_ALUSrc),    0);
        check_eq("rst_ex_ALUOp",   32'(ex_ALUOp),     0);
        check_eq("rst_mem_rd",     32'(mem_MemRead),  0);
        check_eq("rst_mem_wr",     32'(mem_MemWrite), 0);
        check_eq("rst_wb_RegWr",   32'(wb_RegWrite),  0);
        check_eq("rst_wb_MemtoR",  32'(wb_MemtoReg),  0);
        check_eq("rst_wb_dst",     32'(wb_dst),       0);
        check_eq("rst_stall",      32'(stall),        0);
        check_eq("rst_flush_if",   32'(flush_if),     0);
        check_eq("rst_branch",     32'(branch_taken), 0);
        check_eq("rst_jump",       32'(jump_taken),   0);
        check_eq("rst_fwd_a",      32'(fwd_a),        0);
        check_eq("rst_fwd_b",      32'(fwd_b),        0);
    endtask

    // One cycle: drive at negedge, compare, then retire the edge in the model.
    task automatic step(input ins_t cur, input bit z);
        apply(cur, z);
        #1;
        check_all(cur, z);
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (mdl_st || mdl_br) ? ins_t'(0) : cur;
        @(negedge clk);
    endtask

    // A stalled instruction stays in ID (IF/ID is held) until it is accepted.
    task automatic issue(input ins_t i, input bit z);
        step(i, z);
        while (mdl_st) step(i, z);
    endtask

    function automatic ins_t rnd_ins();
        ins_t i;
        i = '0;
        case ($urandom_range(0, 6))
            0: begin i.RegDst = 1; i.RegWrite = 1; i.ALUOp = 2'b10; end
            1: begin i.ALUSrc = 1; i.MemtoReg = 1; i.RegWrite = 1; i.MemRead = 1; end
            2: begin i.ALUSrc = 1; i.MemWrite = 1; end
            3: begin i.Branch = 1; i.ALUOp = 2'b01; end
            4: i.Jump = 1;
            5: begin i.ALUSrc = 1; i.RegWrite = 1; end
            default: {i.RegDst, i.ALUSrc, i.MemtoReg, i.RegWrite, i.MemRead,
                      i.MemWrite, i.Branch, i.Jump, i.ALUOp} = 10'($urandom);
        endcase
        i.rs = 5'($urandom_range(0, 3));
        i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3));
        return i;
    endfunction

    function automatic ins_t mk(input bit [9:0] ctl, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd);
        ins_t i;
        {i.RegDst, i.ALUSrc, i.MemtoReg, i.RegWrite, i.MemRead,
         i.MemWrite, i.Branch, i.Jump, i.ALUOp} = ctl;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    // ctl bit order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump ALUOp[1:0]
    localparam bit [9:0] C_RTYPE = 10'b1001_0000_10;
    localparam bit [9:0] C_LW    = 10'b0111_1000_00;
    localparam bit [9:0] C_J     = 10'b0000_0001_00;
    localparam bit [9:0] C_BRLD  = 10'b0000_1010_01;

    initial begin
        ins_t nop;
        bit   fl;
        nop = '0;
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        apply(nop, 1'b0);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // R-type latency: rd=3, rt=9
        issue(mk(C_RTYPE, 5'd1, 5'd9, 5'd3), 0);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // load-use on rs, then WB forward
        issue(mk(C_LW, 5'd1, 5'd5, 5'd0), 0);
        issue(mk(C_RTYPE, 5'd5, 5'd6, 5'd8), 0);
        issue(nop, 0); issue(nop, 0);
        // MEM beats WB, then MEM writes r0
        issue(mk(C_RTYPE, 5'd1, 5'd2, 5'd7), 0);
        issue(mk(C_RTYPE, 5'd1, 5'd2, 5'd7), 0);
        issue(mk(C_RTYPE, 5'd7, 5'd7, 5'd4), 0);
        issue(mk(C_RTYPE, 5'd1, 5'd2, 5'd7), 0);
        issue(mk(C_RTYPE, 5'd1, 5'd2, 5'd0), 0);
        issue(mk(C_RTYPE, 5'd7, 5'd7, 5'd4), 0);
        issue(nop, 0);
        // taken branch with a load-use hazard and a jump in ID
        issue(mk(C_BRLD, 5'd1, 5'd4, 5'd0), 0);
        issue(mk(C_J, 5'd4, 5'd0, 5'd0), 1);
        issue(nop, 0); issue(nop, 0);
        // register 0 never stalls or forwards
        issue(mk(C_LW, 5'd1, 5'd0, 5'd0), 0);
        issue(mk(C_RTYPE, 5'd0, 5'd0, 5'd2), 0);
        issue(nop, 0); issue(nop, 0);
        // jump delayed by a stall
        issue(mk(C_LW, 5'd1, 5'd3, 5'd0), 0);
        issue(mk(C_J, 5'd3, 5'd1, 5'd0), 0);
        issue(nop, 0);

        fl = 0;
        for (int n = 0; n < 400; n++) begin
            issue(fl ? nop : rnd_ins(), 1'($urandom_range(0, 1)));
            fl = mdl_fl;
        end

        // reset mid-stall with a loaded pipeline
        issue(mk(C_RTYPE, 5'd1, 5'd2, 5'd3), 0);
        issue(mk(C_LW, 5'd1, 5'd2, 5'd0), 0);
        apply(mk(C_RTYPE, 5'd2, 5'd1, 5'd1), 0);
        #1;
        check_all(mk(C_RTYPE, 5'd2, 5'd1, 5'd1), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            issue(fl ? nop : rnd_ins(), 1'($urandom_range(0, 1)));
            fl = mdl_fl;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
